// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
// State encoding, digit-select codes and the WIDTH legality check.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Digit select codes laid out as {neg, sel2x, zero}
    localparam logic [2:0] ZERO = 3'b001;
    localparam logic [2:0] PM1  = 3'b000;
    localparam logic [2:0] NM1  = 3'b100;
    localparam logic [2:0] PM2  = 3'b010;
    localparam logic [2:0] NM2  = 3'b110;

    function automatic bit width_ok(input int w);
        return (w >= 4) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: maps the 3-bit window {q1, q0, q-1} to a
// signed digit in {-2,-1,0,+1,+2} as {neg, sel2x, zero}.
module booth_r4_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] win_i,
    output logic       neg_o,
    output logic       sel2x_o,
    output logic       zero_o
);

    logic [2:0] sel;

    always_comb begin
        sel = ZERO;
        unique case (win_i)
            3'b001, 3'b010: sel = PM1;
            3'b011:         sel = PM2;
            3'b100:         sel = NM2;
            3'b101, 3'b110: sel = NM1;
            default:        sel = ZERO;
        endcase
        {neg_o, sel2x_o, zero_o} = sel;
    end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per clock.
// Define BOOTH_UNSIGNED_EN to add op_signed for unsigned/signed operation.
module booth_r4_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
`ifdef BOOTH_UNSIGNED_EN
    input  logic               op_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int N  = WIDTH / 2 + 1;
    localparam int QW = WIDTH + 2;
    localparam int AW = WIDTH + 4;
`else
    localparam int N  = WIDTH / 2;
    localparam int QW = WIDTH;
    localparam int AW = WIDTH + 2;
`endif
    localparam int CW = $clog2(N + 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("booth_r4_mul_seq: WIDTH must be even and >= 4");
        end
    endgenerate

    state_e             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [AW-1:0]      m_q, m_d;
    logic [QW-1:0]      q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic               m_ext;
    logic [AW-1:0]      m_in;
    logic [QW-1:0]      q_in;

`ifdef BOOTH_UNSIGNED_EN
    logic q_ext;
    assign m_ext = op_signed & M[WIDTH-1];
    assign q_ext = op_signed & Q[WIDTH-1];
    assign q_in  = {{2{q_ext}}, Q};
`else
    assign m_ext = M[WIDTH-1];
    assign q_in  = Q;
`endif
    assign m_in = {{(AW-WIDTH){m_ext}}, M};

    logic               neg, sel2x, zero;
    logic [AW-1:0]      mult, addend, sum;
    logic [AW+QW-1:0]   sh;
    logic [AW-1:0]      a_n;
    logic [QW-1:0]      q_n;
    logic [2*WIDTH-1:0] prod;

    booth_r4_digit_enc u_enc (
        .win_i   ({q_q[1:0], qm1_q}),
        .neg_o   (neg),
        .sel2x_o (sel2x),
        .zero_o  (zero)
    );

    // Add the digit multiple, then shift {A,Q} right by 2 arithmetically
    always_comb begin
        mult   = zero ? '0 : (sel2x ? {m_q[AW-2:0], 1'b0} : m_q);
        addend = neg ? (~mult + AW'(1)) : mult;
        sum    = a_q + addend;
        sh     = {{2{sum[AW-1]}}, sum, q_q[QW-1:2]};
        a_n    = sh[AW+QW-1:QW];
        q_n    = sh[QW-1:0];
        prod   = (2*WIDTH)'({a_n, q_n});
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = m_in;
                    q_d     = q_in;
                    qm1_d   = 1'b0;
                    a_d     = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_n;
                q_d   = q_n;
                qm1_d = q_q[1];
                if (cnt_q == '0) begin
                    p_d     = prod;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign P         = p_q;

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Directed and table-driven bench for booth_r4_mul_seq at WIDTH=8.
// Honours BOOTH_UNSIGNED_EN for the op_signed port and iteration count.
module tb_booth_r4_mul_seq;

    localparam int W = 8;
`ifdef BOOTH_UNSIGNED_EN
    localparam int N = W / 2 + 1;
`else
    localparam int N = W / 2;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   M;
    logic [W-1:0]   Q;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] P;
`ifdef BOOTH_UNSIGNED_EN
    logic           op_signed;
`endif

    int nrun  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    booth_r4_mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .M         (M),
        .Q         (Q),
`ifdef BOOTH_UNSIGNED_EN
        .op_signed (op_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] p;
        string       name;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nrun++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts #1 after a posedge in IDLE; returns #1 after the DONE entry edge
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input string name);
        int lat;
        M        = m;
        Q        = q;
        in_valid = 1'b1;
        chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".latency"}, 32'(lat), 32'(N));
        chk({name, ".P"}, 32'(P), 32'(exp));
    endtask

    task automatic release_chk(input string name);
        @(posedge clk); #1;
        chk({name, ".idle_ready"}, 32'(in_ready), 32'd1);
        chk({name, ".idle_nvalid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0]  rm, rq;
        logic [15:0] re;
        bit          seen;

        vecs[0] = '{8'd3,    8'd5,    16'h000F, "3x5"};
        vecs[1] = '{8'hF9,   8'd6,    16'hFFD6, "m7x6"};
        vecs[2] = '{8'h80,   8'h80,   16'h4000, "min_x_min"};
        vecs[3] = '{8'h7F,   8'h80,   16'hC080, "max_x_min"};
        vecs[4] = '{8'h00,   8'h00,   16'h0000, "zero"};
        vecs[5] = '{8'hFF,   8'hFF,   16'h0001, "m1xm1"};
        vecs[6] = '{8'h7F,   8'h7F,   16'h3F01, "max_x_max"};
        vecs[7] = '{8'hFF,   8'h01,   16'hFFFF, "m1x1"};
        vecs[8] = '{8'h55,   8'hAA,   16'hE372, "85xm86"};
        vecs[9] = '{8'h01,   8'h80,   16'hFF80, "1xmin"};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        M         = '0;
        Q         = '0;
`ifdef BOOTH_UNSIGNED_EN
        op_signed = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.P", 32'(P), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].m, vecs[i].q, vecs[i].p, vecs[i].name);
            release_chk(vecs[i].name);
        end

        // Backpressure: result held, new operands ignored
        out_ready = 1'b0;
        run_op(8'hF9, 8'd6, 16'hFFD6, "bp");
        for (int i = 0; i < 10; i++) begin
            M        = 8'h11;
            Q        = 8'h22;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp.P_hold", 32'(P), 32'hFFD6);
            chk("bp.valid_hold", 32'(out_valid), 32'd1);
            chk("bp.not_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        chk("bp.release_nvalid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp.idle_P_kept", 32'(P), 32'hFFD6);
        chk("bp.no_queue", 32'(in_ready), 32'd1);

        // Reset on the 2nd RUN cycle
        M        = 8'd3;
        Q        = 8'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rrun.in_ready", 32'(in_ready), 32'd1);
        chk("rrun.out_valid", 32'(out_valid), 32'd0);
        chk("rrun.P", 32'(P), 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rrun.no_valid", 32'(seen), 32'd0);
        run_op(8'd3, 8'd5, 16'h000F, "rrun.recover");
        release_chk("rrun.recover");

        for (int i = 0; i < 20; i++) begin
            rm = 8'($urandom_range(0, 255));
            rq = 8'($urandom_range(0, 255));
            re = $signed({{8{rm[7]}}, rm}) * $signed({{8{rq[7]}}, rq});
            run_op(rm, rq, re, $sformatf("rnd%0d", i));
            release_chk($sformatf("rnd%0d", i));
        end

`ifdef BOOTH_UNSIGNED_EN
        op_signed = 1'b0;
        run_op(8'hFF, 8'hFF, 16'hFE01, "uns.ffxff");
        release_chk("uns.ffxff");
        run_op(8'h80, 8'h02, 16'h0100, "uns.128x2");
        release_chk("uns.128x2");
        op_signed = 1'b1;
        run_op(8'hFF, 8'hFF, 16'h0001, "sgn.ffxff");
        release_chk("sgn.ffxff");
`endif

        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
